// File: rtl/bcd_fib_pkg.sv
// Shared definitions for the BCD Fibonacci engine: FSM encoding and
// elaboration-time helpers for limits and parameter legality.
package bcd_fib_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONV = 3'd1,
    FIB  = 3'd2,
    B2B  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic [63:0] pow10(input int k);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < k; i++) r = r * 64'd10;
    return r;
  endfunction

  // Double-dabble digit correction applied before every left shift.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_fib_n_bin2bcd_seq.sv
// Sequential shift-add-3 converter; the first shift happens on the load
// edge so a conversion occupies exactly BW busy cycles including done_tick.
module bin2bcd_seq
  import bcd_fib_pkg::*;
#(
  parameter int BW         = 15,
  parameter int OUT_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BW-1:0]           bin,
  output logic                    done_tick,
  output logic [4*OUT_DIGITS-1:0] bcd
);

  localparam int CW = $clog2(BW + 1);

  logic [BW-1:0]           bin_r;
  logic [4*OUT_DIGITS-1:0] bcd_r;
  logic [4*OUT_DIGITS-1:0] adj;
  logic [CW-1:0]           cnt;
  logic                    busy;

  always_comb begin
    adj = '0;
    for (int i = 0; i < OUT_DIGITS; i++) adj[i*4 +: 4] = add3(bcd_r[i*4 +: 4]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_r <= '0;
      bcd_r <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      bcd_r <= {{(4*OUT_DIGITS-1){1'b0}}, bin[BW-1]};
      bin_r <= {bin[BW-2:0], 1'b0};
      cnt   <= CW'(BW - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        {bcd_r, bin_r} <= {adj[4*OUT_DIGITS-2:0], bin_r, 1'b0};
        cnt            <= cnt - 1'b1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign done_tick = busy && (cnt == '0);
  assign bcd       = bcd_r;

endmodule

// File: rtl/bcd_fib_n.sv
// Parametrised BCD Fibonacci engine: BCD index -> binary, iterative F(n),
// saturation on overflow, then double-dabble back to BCD for display.
module bcd_fib_n
  import bcd_fib_pkg::*;
#(
  parameter int IN_DIGITS  = 2,
  parameter int OUT_DIGITS = 4,
  parameter int NW         = 7,
  parameter int BW         = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*IN_DIGITS-1:0]  bcd_in,
  output logic                    ready,
  output logic                    done_tick,
  output logic                    overflow,
  output logic                    invalid,
  output logic [4*OUT_DIGITS-1:0] bcd_out
);

  localparam logic [63:0]   MAX_V = pow10(OUT_DIGITS) - 64'd1;
  localparam logic [BW-1:0] MAX   = MAX_V[BW-1:0];
  localparam int            DCW   = (IN_DIGITS > 1) ? $clog2(IN_DIGITS) : 1;

  if ((64'd1 << NW) <= pow10(IN_DIGITS) - 64'd1) begin : g_bad_nw
    $error("bcd_fib_n: NW cannot hold the largest index");
  end
  if ((64'd1 << BW) <= 64'd2 * MAX_V) begin : g_bad_bw
    $error("bcd_fib_n: BW cannot hold twice the largest result");
  end

  state_t                  state, state_nxt;
  logic [4*IN_DIGITS-1:0]  din_r;
  logic [DCW-1:0]          dcnt;
  logic [NW-1:0]           n;
  logic [BW-1:0]           t0, t1;
  logic [3:0]              digit;
  logic                    bad_in;
  logic                    fib_end, fib_abort;
  logic                    b2b_done;
  logic [4*OUT_DIGITS-1:0] b2b_bcd;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < IN_DIGITS; i++)
      if (bcd_in[i*4 +: 4] > 4'd9) bad_in = 1'b1;
  end

  assign digit     = din_r[{dcnt, 2'b00} +: 4];
  assign fib_end   = (n == '0);
  assign fib_abort = !fib_end && (t1 > MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = bad_in ? DONE : CONV;
      CONV: if (dcnt == '0) state_nxt = FIB;
      FIB: begin
        if (fib_end)        state_nxt = B2B;
        else if (fib_abort) state_nxt = DONE;
      end
      B2B:  if (b2b_done) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == IDLE);
    done_tick = (state == DONE);
  end

  // Result and flags only move on edges that enter DONE, so they hold between requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din_r    <= '0;
      dcnt     <= '0;
      n        <= '0;
      t0       <= '0;
      t1       <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
      bcd_out  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (bad_in) begin
            invalid  <= 1'b1;
            overflow <= 1'b0;
            bcd_out  <= '0;
          end else begin
            din_r <= bcd_in;
            n     <= '0;
            dcnt  <= DCW'(IN_DIGITS - 1);
          end
        end
        CONV: begin
          n    <= NW'(n * NW'(10) + NW'(digit));
          dcnt <= dcnt - 1'b1;
          if (dcnt == '0) begin
            t0 <= '0;
            t1 <= BW'(1);
          end
        end
        FIB: begin
          if (fib_abort) begin
            overflow <= 1'b1;
            invalid  <= 1'b0;
            bcd_out  <= {OUT_DIGITS{4'h9}};
          end else if (!fib_end) begin
            t0 <= t1;
            t1 <= t0 + t1;
            n  <= n - 1'b1;
          end
        end
        B2B: if (b2b_done) begin
          bcd_out  <= b2b_bcd;
          overflow <= 1'b0;
          invalid  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  bin2bcd_seq #(.BW(BW), .OUT_DIGITS(OUT_DIGITS)) u_b2b (
    .clk       (clk),
    .reset     (reset),
    .start     (state == FIB && fib_end),
    .bin       (t0),
    .done_tick (b2b_done),
    .bcd       (b2b_bcd)
  );

endmodule
